// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader, the instruction memory
// and the fetch path.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W         = 8;
    localparam int IMEM_DATA_W         = 32;
    localparam int IMEM_BYTES_PER_WORD = IMEM_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs bytes MSB-first into one instruction word. It flags the byte that
// completes the word.
module imem_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_W         = IMEM_DATA_W,
    parameter int BYTES_PER_WORD = IMEM_BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic              clr,
    input  logic              accept,
    input  logic [7:0]        in_data,
    output logic [DATA_W-1:0] word_next,
    output logic              word_full
);

    localparam int CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] buf_q;
    logic              last_byte;

    // word_next is the buffer value after this byte, so the top can register it
    // on the same edge that completes the word.
    assign word_next = {buf_q[DATA_W-9:0], in_data};
    assign last_byte = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    assign word_full = accept && last_byte;

    always_ff @(posedge clk) begin
        if (rstd || clr) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else if (accept) begin
            buf_q <= word_next;
            cnt_q <= last_byte ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory writer. It packs the host byte stream into words and
// writes them at consecutive addresses starting at base_addr.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W         = IMEM_ADDR_W,
    parameter int DATA_W         = IMEM_DATA_W,
    parameter int BYTES_PER_WORD = IMEM_BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   ww_q;
    logic [ADDR_W:0]   ww_inc;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              done_q;
    logic              start_ok;
    logic              accept;
    logic              pk_clr;
    logic              word_full;
    logic [DATA_W-1:0] word_next;

    assign in_ready = (state_q == ST_LOAD);
    assign busy     = (state_q != ST_IDLE);
    assign mem_we   = (state_q == ST_WRITE) && !abort;

    assign start_ok = (state_q == ST_IDLE) && start;
    assign accept   = in_ready && in_valid && !abort;
    assign ww_inc   = ww_q + (ADDR_W+1)'(1);
    // An abort in LOAD or WRITE throws away any partial word.
    assign pk_clr   = start_ok || (busy && abort);

    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign done          = done_q;
    assign words_written = ww_q;

    imem_byte_packer #(
        .DATA_W        (DATA_W),
        .BYTES_PER_WORD(BYTES_PER_WORD)
    ) u_packer (
        .clk      (clk),
        .rstd     (rstd),
        .clr      (pk_clr),
        .accept   (accept),
        .in_data  (in_data),
        .word_next(word_next),
        .word_full(word_full)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD:  begin
                if (abort)          state_d = ST_IDLE;
                else if (word_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (abort)                state_d = ST_IDLE;
                else if (ww_inc == len_q) state_d = ST_DONE;
                else                      state_d = ST_LOAD;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstd) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            ww_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == ST_DONE);
            if (start_ok) begin
                addr_q <= base_addr;
                len_q  <= len;
                ww_q   <= '0;
            end
            if (mem_we) begin
                addr_q <= addr_q + ADDR_W'(1);
                ww_q   <= ww_inc;
            end
            // Write port registers load as the word completes, so they are
            // valid during WRITE and then hold.
            if (word_full) begin
                mem_addr_q  <= addr_q;
                mem_wdata_q <= word_next;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader. Expected writes come from a
// word-level model of each load.
module tb_imem_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rstd;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  len;
    logic        abort;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [8:0]  words_written;

    int   tests = 0;
    int   fails = 0;
    int   exp_done = 0;
    int   done_seen = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;
    logic [7:0] pat[$];

    imem_loader dut (
        .clk          (clk),
        .rstd         (rstd),
        .start        (start),
        .base_addr    (base_addr),
        .len          (len),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compares every write against the scoreboard queue.
    always @(negedge clk) begin
        if (rstd === 1'b0) begin
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", mem_addr, mon_e.addr);
                    chk("wr_data", mem_wdata, mon_e.data);
                end
            end
            if (done) done_seen++;
            if (mem_we || done) chk("in_ready_low", in_ready, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b, input int l);
        start     = 1'b1;
        base_addr = 8'(b);
        len       = 9'(l);
        step();
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_words_written"}, words_written, 0);
    endtask

    // One complete load. Expected words come straight from the byte pattern.
    task automatic run_load(input int base, input int ln, input int gmin, input int gmax,
                            input int abort_after, input int start_at);
        int nsend;
        int ncommit;
        while (pat.size() < ln * 4) pat.push_back(8'($urandom));
        nsend   = (abort_after >= 0) ? abort_after : ln * 4;
        ncommit = (abort_after >= 0) ? (abort_after - 1) / 4 : ln;
        for (int k = 0; k < ncommit; k++)
            exp_q.push_back('{addr: 8'((base + k) % 256),
                              data: {pat[4*k], pat[4*k+1], pat[4*k+2], pat[4*k+3]}});
        do_start(base, ln);
        if (ln == 0) begin
            chk("len0_done", done, 1);
            chk("len0_busy", busy, 1);
            exp_done++;
            step();
            chk("len0_idle", busy, 0);
            chk("len0_words", words_written, 0);
            pat.delete();
            return;
        end
        for (int i = 0; i < nsend; i++) begin
            send_byte(pat[i]);
            if (i == start_at) do_start((base + 77) % 256, 1);
            if (i != nsend - 1) repeat ($urandom_range(gmax, gmin)) step();
        end
        if (abort_after >= 0) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("abort_idle", busy, 0);
            chk("abort_words", words_written, ncommit);
            repeat (3) step();
        end else begin
            chk("done_early", done, 0);
            step();
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 1);
            exp_done++;
            chk("words_final", words_written, ln);
            step();
            chk("idle_after_done", busy, 0);
            chk("done_cleared", done, 0);
        end
        pat.delete();
    endtask

    initial begin
        rstd = 1'b1; start = 1'b0; base_addr = '0; len = '0;
        abort = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) step();
        check_reset_outputs("reset");
        rstd = 1'b0;
        step();

        // Two-word load from address 0.
        pat = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h22, 8'hFF, 8'hF0};
        run_load(0, 2, 0, 0, -1, -1);
        // Address wrap 254 -> 255 -> 0.
        run_load(254, 3, 0, 0, -1, -1);
        // in_valid toggling between bytes.
        pat = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(37, 1, 1, 1, -1, -1);
        // Zero-length load.
        run_load(5, 0, 0, 0, -1, -1);
        // Abort partway through the second word, then a normal load.
        run_load(80, 2, 0, 0, 6, -1);
        run_load(120, 1, 0, 2, -1, -1);
        // start during LOAD must be ignored.
        run_load(10, 2, 0, 1, -1, 4);
        // Abort landing on a WRITE cycle.
        run_load(60, 2, 0, 0, 8, -1);

        for (int r = 0; r < 10; r++) begin
            int ln = $urandom_range(5, 1);
            int ab = ($urandom_range(3, 0) == 0) ? $urandom_range(ln * 4, 1) : -1;
            run_load($urandom_range(255, 0), ln, 0, 2, ab, -1);
        end
        // Full 256-word load.
        run_load($urandom_range(255, 0), 256, 0, 0, -1, -1);

        // Reset in the middle of a word.
        do_start(200, 3);
        send_byte(8'hDE);
        send_byte(8'hAD);
        rstd = 1'b1;
        step();
        check_reset_outputs("midreset");
        rstd = 1'b0;
        step();
        pat = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
        run_load(7, 1, 0, 1, -1, -1);

        repeat (4) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("done_count", done_seen, exp_done);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: takes a byte stream from the host/debug link and packs it MSB-first into 32-bit instruction words.
- Writes each word into the instruction memory write port at consecutive addresses from a programmable base.
- The fetch datapath reads the same memory asynchronously by pc.
- Holds the core's pc logic in reset via busy while loading.

Parameters:
ADDR_W, 8, instruction memory address width (256 words)
DATA_W, 32, instruction word width
BYTES_PER_WORD, 4, bytes packed per word (DATA_W/8)

Ports:
clk  input  1  system clock, all state updates on rising edge
rstd  input  1  synchronous active-high reset
start  input  1  one-cycle request to begin a load; honoured only in IDLE
base_addr  input  ADDR_W  first word address, sampled on accepted start
len  input  ADDR_W+1  number of words to load, 0..256, sampled on accepted start
abort  input  1  cancel load, discard partial word
in_valid  input  1  byte available
in_data  input  8  byte value
in_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  instruction memory write enable
mem_addr  output  ADDR_W  write address
mem_wdata  output  DATA_W  write data
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when the last word is written
words_written  output  ADDR_W+1  words committed in the current or most recent load

Behaviour:
- Reset (rstd=1 at a rising edge): state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, words_written=0, byte counter=0, shift buffer=0. Reset overrides every other input, mid-load included.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - On start with len>0: latch base_addr into the address counter, latch len, clear words_written and byte counter, go to LOAD next cycle.
  - On start with len==0: go to DONE directly.
  - start outside IDLE is ignored.
- LOAD:
  - in_ready=1.
  - A byte is accepted on a rising edge with in_valid&&in_ready.
  - On acceptance: buffer <= {buffer[23:0], in_data} (first byte lands in bits 31:24) and the byte counter increments.
  - The 4th accepted byte resets the byte counter to 0 and moves to WRITE.
  - in_valid low stalls indefinitely with no timeout.
- WRITE (exactly one cycle):
  - in_ready=0, mem_we=1, mem_addr=address counter, mem_wdata=buffer.
  - On exit: address counter +1, wrapping 255->0; words_written +1.
  - If the new words_written equals len, go to DONE; otherwise go to LOAD.
- DONE (one cycle): done=1, busy=1, in_ready=0, then IDLE.
- Latency: the word is written 1 cycle after its 4th byte is accepted. Peak throughput is 4 bytes per 5 cycles.
- mem_addr and mem_wdata hold their last values outside WRITE. mem_we is high only in WRITE.
- abort:
  - In LOAD or WRITE, abort takes priority over byte acceptance and the write: mem_we forced 0, go to IDLE next cycle, no done pulse, partial buffer discarded.
  - words_written keeps the count of words already committed.
  - abort in IDLE or DONE has no effect; DONE still pulses.
- A simultaneous start and abort in IDLE is treated as start.
- All outputs are registered, except in_ready, busy and mem_we, which decode directly from the state register.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, LOAD=2'd1, WRITE=2'd2, DONE=2'd3)
  - ADDR_W, DATA_W and BYTES_PER_WORD constants, also consumed by the instruction memory and fetch
- One natural sub-module, imem_byte_packer: shift buffer plus byte counter, with a word_full flag output. The FSM and address/word counters stay in the top.

Test Plan:
1. Reset, then start with base=0, len=2; bytes 8C,01,00,04,AC,22,FF,F0 with in_valid held high -> mem_we pulses twice: addr0=0x8C010004, then addr1=0xAC22FFF0. done pulses 1 cycle after the 2nd write. words_written=2.
2. Base=254, len=3, 12 bytes -> writes to addresses 254, 255, 0 (wrap). done asserted. busy low the cycle after done.
3. in_valid toggled 1-0-1 on every byte, len=1, data 11,22,33,44 -> single write 0x11223344 at base. in_ready drops only in WRITE and DONE.
4. len=0 start -> no mem_we. done pulses on the cycle after start. words_written=0.
5. len=2, abort after 6 bytes -> first word written, second never written. No done. words_written=1. A new start then loads normally from the new base.
6. rstd high in the middle of a word, then start pulsed during LOAD -> reset clears all state and outputs. A start issued during a load does not restart the address counter.
